// File: rtl/lane_arbiter.sv
// Round-robin merge of LANES router read ports onto one registered valid/ready output.
// One lane read is in flight at a time; each word is tagged with its source lane.
module lane_arbiter #(
    parameter int DATA  = 64,
    parameter int LANES = 4,
    parameter int SEL   = 2
) (
    input  logic                        clK,
    input  logic                        rsT,
    input  logic [LANES-1:0]            REQ,
    input  logic [LANES-1:0][DATA-1:0]  IN,
    output logic [LANES-1:0]            RD,
    output logic [DATA-1:0]             o_DATA,
    output logic [SEL-1:0]              o_LANE,
    output logic                        o_VALID,
    input  logic                        o_READY,
    output logic                        BUSY
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [SEL-1:0]    ptr_q, ptr_d;
    logic [SEL-1:0]    grant_q, grant_d;
    logic [LANES-1:0]  rd_q, rd_d;
    logic [DATA-1:0]   data_q, data_d;
    logic [SEL-1:0]    lane_q, lane_d;
    logic              valid_q, valid_d;

    logic [SEL-1:0]    g;
    logic [SEL-1:0]    g_ptr;

    // Scan from the highest rotation offset down so the lane nearest ptr wins.
    always_comb begin
        logic [SEL:0]   sum;
        logic [SEL-1:0] idx;
        g   = '0;
        sum = '0;
        idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (SEL+1)'(k);
            if (sum >= (SEL+1)'(LANES)) begin
                sum = sum - (SEL+1)'(LANES);
            end
            idx = sum[SEL-1:0];
            if (REQ[idx]) begin
                g = idx;
            end
        end
        g_ptr = (g == SEL'(LANES - 1)) ? '0 : g + SEL'(1);
    end

    always_comb begin
        logic take;
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        rd_d    = '0;
        data_d  = data_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        take    = 1'b0;

        unique case (state_q)
            IDLE: begin
                take = |REQ;
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                data_d  = IN[grant_q];
                lane_d  = grant_q;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (o_READY) begin
                    valid_d = 1'b0;
                    take    = |REQ;
                    if (!(|REQ)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            rd_d    = LANES'(1) << g;
            grant_d = g;
            ptr_d   = g_ptr;
            state_d = ISSUE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clK or posedge rsT) begin
        if (rsT) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
        end
    end

    // A read strobed just before reset is dropped; the lane has already popped it.
    assign RD      = rd_q;
    assign o_DATA  = data_q;
    assign o_LANE  = lane_q;
    assign o_VALID = valid_q;
    assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_lane_arbiter.sv
// Self-checking bench for lane_arbiter: scenario tasks with a scoreboard of
// expected (lane, data) words popped as the output is accepted.
module tb_lane_arbiter;

    localparam int DATA  = 64;
    localparam int LANES = 4;
    localparam int SEL   = 2;

    typedef struct packed {
        logic [SEL-1:0]  lane;
        logic [DATA-1:0] data;
    } word_t;

    logic                       clK = 1'b0;
    logic                       rsT = 1'b1;
    logic [LANES-1:0]           REQ = '0;
    logic [LANES-1:0][DATA-1:0] in_w = '0;
    logic [LANES-1:0]           RD;
    logic [DATA-1:0]            o_DATA;
    logic [SEL-1:0]             o_LANE;
    logic                       o_VALID;
    logic                       o_READY = 1'b0;
    logic                       BUSY;

    int    chk_cnt  = 0;
    int    pass_cnt = 0;
    word_t exp_q[$];

    lane_arbiter #(.DATA(DATA), .LANES(LANES), .SEL(SEL)) dut (
        .clK     (clK),
        .rsT     (rsT),
        .REQ     (REQ),
        .IN      (in_w),
        .RD      (RD),
        .o_DATA  (o_DATA),
        .o_LANE  (o_LANE),
        .o_VALID (o_VALID),
        .o_READY (o_READY),
        .BUSY    (BUSY)
    );

    always #5 clK = ~clK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clK);
    endtask

    task automatic push_exp(input logic [SEL-1:0] lane, input logic [DATA-1:0] data);
        word_t w;
        w.lane = lane;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Waits (bounded) for an accepted word, compares it to the scoreboard head, then steps past the accepting edge.
    task automatic wait_word(input string name, input int budget);
        word_t e;
        int    n = 0;
        while (!(o_VALID === 1'b1 && o_READY === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: got lane %0d data %h, scoreboard empty", name, o_LANE, o_DATA);
        end else begin
            e = exp_q.pop_front();
            if (!(o_VALID === 1'b1 && o_READY === 1'b1))
                $display("FAIL %s: no word within %0d cycles, want lane %0d data %h", name, budget, e.lane, e.data);
            else if (o_LANE !== e.lane || o_DATA !== e.data)
                $display("FAIL %s: got lane %0d data %h, want lane %0d data %h", name, o_LANE, o_DATA, e.lane, e.data);
            else
                pass_cnt++;
        end
        tick();
    endtask

    task automatic do_reset();
        tick();
        rsT     = 1'b1;
        REQ     = '0;
        o_READY = 1'b0;
        tick();
        rsT     = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        tick();
        chk_cnt++;
        if (RD !== '0 || o_DATA !== '0 || o_LANE !== '0 || o_VALID !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL por_state: got RD %b data %h lane %0d valid %b busy %b, want all zero", RD, o_DATA, o_LANE, o_VALID, BUSY);
        else
            pass_cnt++;
        rsT = 1'b0;

        // Park a word in HOLD, then hit reset between clock edges.
        in_w[0] = 64'hAA;
        REQ     = 4'b0001;
        o_READY = 1'b0;
        while (o_VALID !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (o_VALID !== 1'b1 || o_DATA !== 64'hAA || o_LANE !== 2'd0)
            $display("FAIL hold_before_reset: got valid %b data %h lane %0d, want 1 aa 0", o_VALID, o_DATA, o_LANE);
        else
            pass_cnt++;
        #2;
        rsT = 1'b1;
        #1;
        chk_cnt++;
        if (o_VALID !== 1'b0) $display("FAIL async_valid: got %b want 0", o_VALID);
        else pass_cnt++;
        chk_cnt++;
        if (o_DATA !== '0) $display("FAIL async_data: got %h want 0", o_DATA);
        else pass_cnt++;
        chk_cnt++;
        if (RD !== '0) $display("FAIL async_rd: got %b want 0000", RD);
        else pass_cnt++;
        chk_cnt++;
        if (BUSY !== 1'b0) $display("FAIL async_busy: got %b want 0", BUSY);
        else pass_cnt++;

        REQ     = 4'b0100;
        in_w[2] = 64'h77;
        tick();
        rsT = 1'b0;
        tick();
        chk_cnt++;
        if (RD !== 4'b0100) $display("FAIL post_reset_rd: got %b want 0100", RD);
        else pass_cnt++;
        REQ     = '0;
        o_READY = 1'b1;
        push_exp(2'd2, 64'h77);
        wait_word("post_reset_word", 4);
    endtask

    task automatic test_single();
        do_reset();
        in_w[1] = 64'h1234_5678_9ABC_DEF0;
        REQ     = 4'b0010;
        o_READY = 1'b1;
        push_exp(2'd1, 64'h1234_5678_9ABC_DEF0);
        tick();
        chk_cnt++;
        if (RD !== 4'b0010 || BUSY !== 1'b1) $display("FAIL single_rd: got RD %b busy %b, want 0010 1", RD, BUSY);
        else pass_cnt++;
        REQ = '0;
        tick();
        chk_cnt++;
        if (RD !== '0 || o_VALID !== 1'b0) $display("FAIL single_rd_pulse: got RD %b valid %b, want 0000 0", RD, o_VALID);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (o_VALID !== 1'b1) $display("FAIL single_latency: got valid %b want 1", o_VALID);
        else pass_cnt++;
        wait_word("single_word", 0);
        chk_cnt++;
        if (o_VALID !== 1'b0 || BUSY !== 1'b0) $display("FAIL single_after: got valid %b busy %b, want 0 0", o_VALID, BUSY);
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        time t_prev = 0;
        do_reset();
        for (int i = 0; i < LANES; i++) in_w[i] = 64'(i);
        REQ     = 4'b1111;
        o_READY = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < LANES; i++) push_exp(SEL'(i), 64'(i));
        for (int i = 0; i < 8; i++) begin
            wait_word("fair_word", 4);
            if (i > 0) begin
                chk_cnt++;
                if ($time - t_prev !== 30) $display("FAIL fair_spacing: got %0t between words, want 30", $time - t_prev);
                else pass_cnt++;
            end
            t_prev = $time;
            if (i == 6) REQ = '0;
        end
        chk_cnt++;
        if (BUSY !== 1'b0) $display("FAIL fair_idle: got busy %b want 0", BUSY);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        in_w[0] = 64'hA0;
        in_w[2] = 64'hA2;
        REQ     = 4'b0100;
        o_READY = 1'b1;
        push_exp(2'd2, 64'hA2);
        push_exp(2'd0, 64'hA0);
        push_exp(2'd2, 64'hA2);
        push_exp(2'd0, 64'hA0);
        tick();
        chk_cnt++;
        if (RD !== 4'b0100) $display("FAIL wrap_first_rd: got %b want 0100", RD);
        else pass_cnt++;
        REQ = 4'b0101;
        wait_word("wrap_lane2", 4);
        chk_cnt++;
        if (RD !== 4'b0001) $display("FAIL wrap_rd_lane0: got %b want 0001", RD);
        else pass_cnt++;
        wait_word("wrap_lane0", 4);
        wait_word("wrap_lane2b", 4);
        REQ = '0;
        wait_word("wrap_lane0b", 4);
        chk_cnt++;
        if (BUSY !== 1'b0) $display("FAIL wrap_idle: got busy %b want 0", BUSY);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        in_w[0] = 64'h5A5A_5A5A_5A5A_5A5A;
        in_w[3] = 64'hC3C3_0000_C3C3_0000;
        REQ     = 4'b0001;
        o_READY = 1'b0;
        tick();
        REQ = 4'b1000;
        while (o_VALID !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk_cnt++;
            if (o_VALID !== 1'b1 || o_DATA !== 64'h5A5A_5A5A_5A5A_5A5A || o_LANE !== 2'd0 || RD !== '0)
                $display("FAIL bp_stable: cycle %0d got valid %b data %h lane %0d RD %b, want 1 5a5a5a5a5a5a5a5a 0 0000", i, o_VALID, o_DATA, o_LANE, RD);
            else
                pass_cnt++;
            tick();
        end
        o_READY = 1'b1;
        push_exp(2'd0, 64'h5A5A_5A5A_5A5A_5A5A);
        push_exp(2'd3, 64'hC3C3_0000_C3C3_0000);
        wait_word("bp_word0", 0);
        chk_cnt++;
        if (RD !== 4'b1000) $display("FAIL bp_next_rd: got %b want 1000", RD);
        else pass_cnt++;
        REQ = '0;
        wait_word("bp_word3", 4);
    endtask

    task automatic test_late_drop();
        do_reset();
        in_w[2] = 64'hDEAD_BEEF_0000_0002;
        REQ     = 4'b0100;
        o_READY = 1'b1;
        push_exp(2'd2, 64'hDEAD_BEEF_0000_0002);
        tick();
        chk_cnt++;
        if (RD !== 4'b0100) $display("FAIL drop_rd: got %b want 0100", RD);
        else pass_cnt++;
        REQ = '0;
        tick();
        chk_cnt++;
        if (RD !== '0) $display("FAIL drop_no_rd_wait: got %b want 0000", RD);
        else pass_cnt++;
        tick();
        wait_word("drop_word", 0);
        chk_cnt++;
        if (RD !== '0 || BUSY !== 1'b0) $display("FAIL drop_after: got RD %b busy %b, want 0000 0", RD, BUSY);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_late_drop();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d words left, want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
